alu_wide_serial: RTL and testbench

Parametrised, byte-serial successor of the 65CE02 ALU. It executes the same op set on operands `NBYTES` bytes wide (default 2, for 65CE02 word ops such as INW/ASW/PHW), one byte per clock. Unlike the single-byte ALU, it has correct BCD subtract and a start/busy/done handshake. It sits beside the byte ALU in the core datapath and is also reused by the monitor's multi-precision math routines.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_wide_serial_if.sv | 29 ++
 rtl/alu_byte_slice.sv | 71 +++++++
 rtl/alu_wide_serial.sv | 150 +++++++++++++++
 tb/tb_alu_wide_serial.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings, FSM states and BCD nibble helper for the serial ALU
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_ASL  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1101;
    localparam logic [3:0] ALU_EOR  = 4'b1110;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    // Returns {nibble_carry, nibble}; subtract corrects on borrow (carry out 0).
    function automatic logic [4:0] bcd_fix(input logic [4:0] s, input logic sub);
        logic [4:0] r;
        r = s;
        if (sub) begin
            if (!s[4]) r = {1'b0, s[3:0] - 4'd6};
        end else if (s > 5'd9) begin
            r = {1'b1, s[3:0] + 4'd6};
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_wide_serial_if.sv
// rtl/alu_wide_serial_if.sv - request/result bundle of the byte-serial ALU
interface alu_wide_serial_if #(parameter int NBYTES = 2) ();
    logic                  start;
    logic [3:0]            op;
    logic                  right;
    logic                  arith;
    logic [8*NBYTES-1:0]   AI;
    logic [8*NBYTES-1:0]   BI;
    logic                  CI;
    logic                  BCD;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   OUT;
    logic                  CO;
    logic                  V;
    logic                  N;
    logic                  Z;
    logic                  HC;

    modport master (
        output start, op, right, arith, AI, BI, CI, BCD,
        input  busy, done, OUT, CO, V, N, Z, HC
    );

    modport slave (
        input  start, op, right, arith, AI, BI, CI, BCD,
        output busy, done, OUT, CO, V, N, Z, HC
    );
endinterface

// File: rtl/alu_byte_slice.sv
// rtl/alu_byte_slice.sv - combinational one-byte step: add/sub/asl with BCD, logic, right shift
module alu_byte_slice
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [3:0] op,
    input  logic       right,
    input  logic       fill,
    input  logic       bcd,
    output logic [7:0] y,
    output logic       cout,
    output logic       hc,
    output logic       vbin
);
    logic [7:0] bp;
    logic       add_op;
    logic       sub;
    logic       dec;
    logic [8:0] bin;
    logic [4:0] lo;
    logic [4:0] lo_f;
    logic [4:0] hi;
    logic [4:0] hi_f;

    always_comb begin
        bp     = a;
        add_op = 1'b0;
        sub    = 1'b0;
        y      = a;
        cout   = 1'b0;
        hc     = 1'b0;
        vbin   = 1'b0;
        bin    = '0;
        lo     = '0;
        lo_f   = '0;
        hi     = '0;
        hi_f   = '0;
        unique case (op)
            ALU_ADD: begin bp = b;  add_op = 1'b1; end
            ALU_SUB: begin bp = ~b; add_op = 1'b1; sub = 1'b1; end
            ALU_ASL: begin bp = a;  add_op = 1'b1; end
            default: bp = a;
        endcase
        dec = bcd && (op == ALU_ADD || op == ALU_SUB);

        if (right) begin
            y    = {fill, a[7:1]};
            cout = a[0];
        end else if (add_op) begin
            bin  = {1'b0, a} + {1'b0, bp} + {8'b0, cin};
            vbin = a[7] ^ bp[7] ^ bin[8] ^ bin[7];
            lo   = {1'b0, a[3:0]} + {1'b0, bp[3:0]} + {4'b0, cin};
            lo_f = dec ? bcd_fix(lo, sub) : lo;
            hi   = {1'b0, a[7:4]} + {1'b0, bp[7:4]} + {4'b0, lo_f[4]};
            hi_f = bcd_fix(hi, sub);
            y    = dec ? {hi_f[3:0], lo_f[3:0]} : bin[7:0];
            cout = dec ? hi_f[4] : bin[8];
            hc   = lo_f[4];
        end else begin
            // Logic ops never propagate a carry.
            unique case (op)
                ALU_OR:  y = a | b;
                ALU_AND: y = a & b;
                ALU_EOR: y = a ^ b;
                default: y = a;
            endcase
        end
    end
endmodule

// File: rtl/alu_wide_serial.sv
// rtl/alu_wide_serial.sv - NBYTES-wide ALU processing one byte per clock with start/busy/done
module alu_wide_serial
    import alu_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               RDY,
    alu_wide_serial_if.slave   bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    alu_state_e             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NBYTES-1:0][7:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]             op_q, op_d;
    logic                   right_q, right_d, bcd_q, bcd_d;
    logic                   carry_q, carry_d, hcs_q, hcs_d;
    logic [W-1:0]           out_q, out_d;
    logic                   co_q, co_d, v_q, v_d, n_q, n_d, z_q, z_d, hc_q, hc_d;
    logic                   accept, last_step;
    logic [7:0]             s_y;
    logic                   s_cout, s_hc, s_vbin;

    assign accept    = RDY && bus.start && (state_q != S_RUN);
    assign last_step = right_q ? (idx_q == '0) : (idx_q == LAST);

    // carry_q doubles as the right-shift fill: it holds the bit entering the current byte.
    alu_byte_slice u_slice (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .cin   (carry_q),
        .op    (op_q),
        .right (right_q),
        .fill  (carry_q),
        .bcd   (bcd_q),
        .y     (s_y),
        .cout  (s_cout),
        .hc    (s_hc),
        .vbin  (s_vbin)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (RDY) begin
            unique case (state_q)
                S_IDLE:  if (accept) state_d = S_RUN;
                S_RUN:   if (last_step) state_d = S_DONE;
                S_DONE:  state_d = accept ? S_RUN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
    end

    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        right_d = right_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        hcs_d   = hcs_q;
        out_d   = out_q;
        co_d    = co_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
        hc_d    = hc_q;
        if (accept) begin
            a_d     = bus.AI;
            b_d     = bus.BI;
            op_d    = bus.op;
            right_d = bus.right;
            bcd_d   = bus.BCD;
            carry_d = (bus.right && bus.arith) ? bus.AI[W-1] : bus.CI;
            idx_d   = bus.right ? LAST : '0;
        end else if (RDY && state_q == S_RUN) begin
            res_d[idx_q] = s_y;
            carry_d      = s_cout;
            idx_d        = right_q ? idx_q - IW'(1) : idx_q + IW'(1);
            if (idx_q == '0) hcs_d = s_hc;
            if (last_step) begin
                out_d = res_d;
                co_d  = s_cout;
                v_d   = s_vbin;
                n_d   = res_d[NBYTES-1][7];
                z_d   = (res_d == '0);
                hc_d  = (idx_q == '0) ? s_hc : hcs_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            right_q <= 1'b0;
            bcd_q   <= 1'b0;
            carry_q <= 1'b0;
            hcs_q   <= 1'b0;
            out_q   <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            hc_q    <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            right_q <= right_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            hcs_q   <= hcs_d;
            out_q   <= out_d;
            co_q    <= co_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            hc_q    <= hc_d;
        end
    end

    assign bus.OUT = out_q;
    assign bus.CO  = co_q;
    assign bus.V   = v_q;
    assign bus.N   = n_q;
    assign bus.Z   = z_q;
    assign bus.HC  = hc_q;
endmodule

// File: tb/tb_alu_wide_serial.sv
// tb/tb_alu_wide_serial.sv - directed self-checking bench for alu_wide_serial (NBYTES=2)
module tb_alu_wide_serial;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic RDY = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat;
    logic [5:0] done_seq;
    logic [5:0] busy_seq;

    alu_wide_serial_if #(.NBYTES(2)) bus ();

    alu_wide_serial #(.NBYTES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .RDY     (RDY),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp_v);
        end
    endtask

    task automatic set_req(input logic [3:0] op_i, input logic right_i, input logic arith_i,
                           input logic bcd_i, input logic ci_i,
                           input logic [15:0] ai, input logic [15:0] bi);
        bus.op    = op_i;
        bus.right = right_i;
        bus.arith = arith_i;
        bus.BCD   = bcd_i;
        bus.CI    = ci_i;
        bus.AI    = ai;
        bus.BI    = bi;
    endtask

    // lat counts edges from the cycle start is presented until done is seen; 0 = timeout.
    task automatic run_op(input logic [3:0] op_i, input logic right_i, input logic arith_i,
                          input logic bcd_i, input logic ci_i,
                          input logic [15:0] ai, input logic [15:0] bi,
                          input int stall_at, output int lat_o);
        set_req(op_i, right_i, arith_i, bcd_i, ci_i, ai, bi);
        bus.start = 1'b1;
        lat_o = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus.start = 1'b0;
                chk("busy_in_run", {15'd0, bus.busy}, 16'd1);
            end
            if (stall_at != 0 && c == stall_at) RDY = 1'b0;
            if (stall_at != 0 && c == stall_at + 3) RDY = 1'b1;
            if (bus.done) begin
                lat_o = c;
                break;
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        set_req(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  bus.OUT, 16'h0000);
        chk("rst_co",   {15'd0, bus.CO}, 16'd0);
        chk("rst_v",    {15'd0, bus.V}, 16'd0);
        chk("rst_n",    {15'd0, bus.N}, 16'd0);
        chk("rst_hc",   {15'd0, bus.HC}, 16'd0);
        chk("rst_z",    {15'd0, bus.Z}, 16'd1);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 12FF + 0001
        run_op(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h12FF, 16'h0001, 0, lat);
        chk("add_lat", 16'(lat), 16'd3);
        chk("add_out", bus.OUT, 16'h1300);
        chk("add_co",  {15'd0, bus.CO}, 16'd0);
        chk("add_z",   {15'd0, bus.Z}, 16'd0);
        chk("add_hc",  {15'd0, bus.HC}, 16'd1);
        chk("add_v",   {15'd0, bus.V}, 16'd0);
        chk("add_busy_done", {15'd0, bus.busy}, 16'd0);

        // done held through a stall, then drops
        RDY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stretch_done", {15'd0, bus.done}, 16'd1);
        RDY = 1'b1;
        @(posedge clk); #1;
        chk("stretch_end", {15'd0, bus.done}, 16'd0);
        chk("stretch_out", bus.OUT, 16'h1300);

        // BCD 1000 - 0001
        run_op(ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1000, 16'h0001, 0, lat);
        chk("bsub_out", bus.OUT, 16'h0999);
        chk("bsub_co",  {15'd0, bus.CO}, 16'd1);
        chk("bsub_n",   {15'd0, bus.N}, 16'd0);
        chk("bsub_hc",  {15'd0, bus.HC}, 16'd0);

        // BCD 9999 + 0001
        run_op(ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 16'h0001, 0, lat);
        chk("badd_out", bus.OUT, 16'h0000);
        chk("badd_co",  {15'd0, bus.CO}, 16'd1);
        chk("badd_z",   {15'd0, bus.Z}, 16'd1);
        chk("badd_hc",  {15'd0, bus.HC}, 16'd1);

        // arithmetic right shift 8001
        run_op(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8001, 16'h0000, 0, lat);
        chk("asr_lat", 16'(lat), 16'd3);
        chk("asr_out", bus.OUT, 16'hC000);
        chk("asr_co",  {15'd0, bus.CO}, 16'd1);
        chk("asr_n",   {15'd0, bus.N}, 16'd1);

        // logical right shift with CI fill
        run_op(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, 0, lat);
        chk("lsr_out", bus.OUT, 16'h8001);
        chk("lsr_co",  {15'd0, bus.CO}, 16'd0);

        // ROL: C001 with CI=1
        run_op(ALU_ASL, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC001, 16'h0000, 0, lat);
        chk("rol_out", bus.OUT, 16'h8003);
        chk("rol_co",  {15'd0, bus.CO}, 16'd1);

        // binary 0005 - 0007
        run_op(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0007, 0, lat);
        chk("sub_out", bus.OUT, 16'hFFFE);
        chk("sub_co",  {15'd0, bus.CO}, 16'd0);
        chk("sub_n",   {15'd0, bus.N}, 16'd1);
        chk("sub_v",   {15'd0, bus.V}, 16'd0);

        // logic ops, CI=1 must not leak into CO
        run_op(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0FF0, 16'h3C3C, 0, lat);
        chk("and_out", bus.OUT, 16'h0C30);
        chk("and_co",  {15'd0, bus.CO}, 16'd0);
        run_op(ALU_EOR, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 0, lat);
        chk("eor_out", bus.OUT, 16'h0000);
        chk("eor_z",   {15'd0, bus.Z}, 16'd1);
        run_op(ALU_OR, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1200, 16'h0034, 0, lat);
        chk("or_out",  bus.OUT, 16'h1234);

        // signed overflow with a 3-cycle RDY stall mid-RUN
        run_op(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 2, lat);
        chk("ovf_lat", 16'(lat), 16'd6);
        chk("ovf_out", bus.OUT, 16'h8000);
        chk("ovf_v",   {15'd0, bus.V}, 16'd1);
        chk("ovf_n",   {15'd0, bus.N}, 16'd1);
        chk("ovf_co",  {15'd0, bus.CO}, 16'd0);

        // back-to-back with start held
        @(posedge clk); #1;
        set_req(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 16'h0202);
        bus.start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            done_seq[c] = bus.done;
            busy_seq[c] = bus.busy;
        end
        bus.start = 1'b0;
        chk("b2b_done", {10'd0, done_seq}, 16'b10_0100);
        chk("b2b_busy", {10'd0, busy_seq}, 16'b01_1011);
        chk("b2b_out",  bus.OUT, 16'h0303);
        @(posedge clk); #1;
        chk("b2b_idle", {14'd0, bus.busy, bus.done}, 16'd0);

        // reset mid-RUN
        set_req(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0002);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_out",  bus.OUT, 16'h0000);
        chk("arst_z",    {15'd0, bus.Z}, 16'd1);
        chk("arst_busy", {15'd0, bus.busy}, 16'd0);
        chk("arst_flags", {12'd0, bus.CO, bus.V, bus.N, bus.HC}, 16'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_done", {15'd0, bus.done}, 16'd0);

        // new op after reset; a start during busy is ignored
        set_req(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1111);
        bus.start = 1'b1;
        @(posedge clk); #1;
        set_req(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("post_done", {15'd0, bus.done}, 16'd1);
        chk("post_out",  bus.OUT, 16'h2345);
        @(posedge clk); #1;
        chk("ign_busy",  {15'd0, bus.busy}, 16'd0);
        chk("ign_done",  {15'd0, bus.done}, 16'd0);
        chk("ign_out",   bus.OUT, 16'h2345);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
